// File: rtl/agu_tile_sched.sv
// Walks a layer's tiles (ch outer, ty, tx inner) and issues one AGU configuration per tile.
// Config fields are registered in LOAD/NEXT and held until the next tile; start pulses in ISSUE.
module agu_tile_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [5:0] cmd_tile_x,
  input  logic [5:0] cmd_tile_y,
  input  logic [7:0] cmd_ch_grp,
  input  logic [7:0] cmd_idx_cnt,
  input  logic [7:0] cmd_trip_cnt,
  input  logic       cmd_odd_h,
  input  logic       abort,
  input  logic       agu_done,
  output logic       start,
  output logic [1:0] mode,
  output logic [7:0] idx_cnt,
  output logic [7:0] trip_cnt,
  output logic       is_new,
  output logic [3:0] pad_code,
  output logic       cut_y,
  output logic       busy,
  output logic       layer_done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_NEXT} state_t;

  state_t     state_q, state_d;
  logic [5:0] tx_lim_q, tx_lim_d, ty_lim_q, ty_lim_d;
  logic [7:0] cg_lim_q, cg_lim_d;
  logic [1:0] cfg_mode_q, cfg_mode_d;
  logic [7:0] cfg_idx_q, cfg_idx_d, cfg_trip_q, cfg_trip_d;
  logic       cfg_odd_q, cfg_odd_d;
  logic [5:0] tx_q, tx_d, ty_q, ty_d;
  logic [7:0] ch_q, ch_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] idx_q, idx_d, trip_q, trip_d;
  logic       is_new_q, is_new_d;
  logic [3:0] pad_q, pad_d;
  logic       cut_q, cut_d;
  logic       ld_q, ld_d;

  logic tx_last, ty_last, ch_last, cfg_fc;

  assign tx_last = (tx_q == tx_lim_q - 6'd1);
  assign ty_last = (ty_q == ty_lim_q - 6'd1);
  assign ch_last = (ch_q == cg_lim_q - 8'd1);
  assign cfg_fc  = cfg_mode_q[0];

  // The completion pulse cycle still reads as IDLE but cannot accept, so a new
  // command lands two cycles after the final agu_done.
  assign cmd_ready  = (state_q == S_IDLE) && !ld_q;
  assign busy       = (state_q != S_IDLE);
  assign start      = (state_q == S_ISSUE);
  assign mode       = mode_q;
  assign idx_cnt    = idx_q;
  assign trip_cnt   = trip_q;
  assign is_new     = is_new_q;
  assign pad_code   = pad_q;
  assign cut_y      = cut_q;
  assign layer_done = ld_q;

  always_comb begin
    state_d    = state_q;
    tx_lim_d   = tx_lim_q;
    ty_lim_d   = ty_lim_q;
    cg_lim_d   = cg_lim_q;
    cfg_mode_d = cfg_mode_q;
    cfg_idx_d  = cfg_idx_q;
    cfg_trip_d = cfg_trip_q;
    cfg_odd_d  = cfg_odd_q;
    tx_d       = tx_q;
    ty_d       = ty_q;
    ch_d       = ch_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    trip_d     = trip_q;
    is_new_d   = is_new_q;
    pad_d      = pad_q;
    cut_d      = cut_q;
    ld_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          // FC layers collapse the spatial loops to a single tile.
          tx_lim_d   = (cmd_mode[0] || cmd_tile_x == 6'd0) ? 6'd1 : cmd_tile_x;
          ty_lim_d   = (cmd_mode[0] || cmd_tile_y == 6'd0) ? 6'd1 : cmd_tile_y;
          cg_lim_d   = (cmd_ch_grp == 8'd0) ? 8'd1 : cmd_ch_grp;
          cfg_mode_d = cmd_mode;
          cfg_idx_d  = cmd_idx_cnt;
          cfg_trip_d = cmd_trip_cnt;
          cfg_odd_d  = cmd_odd_h;
          tx_d       = 6'd0;
          ty_d       = 6'd0;
          ch_d       = 8'd0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD, S_NEXT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          mode_d   = cfg_mode_q;
          idx_d    = cfg_idx_q;
          trip_d   = cfg_trip_q;
          is_new_d = (ch_q == 8'd0);
          pad_d    = cfg_fc ? 4'd0 : {tx_last, tx_q == 6'd0, ty_last, ty_q == 6'd0};
          cut_d    = !cfg_fc && cfg_odd_q && ty_last;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: state_d = abort ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (agu_done) begin
          if (tx_last && ty_last && ch_last) begin
            ld_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_NEXT;
            if (tx_last) begin
              tx_d = 6'd0;
              if (ty_last) begin
                ty_d = 6'd0;
                ch_d = ch_q + 8'd1;
              end else begin
                ty_d = ty_q + 6'd1;
              end
            end else begin
              tx_d = tx_q + 6'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_lim_q   <= 6'd1;
      ty_lim_q   <= 6'd1;
      cg_lim_q   <= 8'd1;
      cfg_mode_q <= 2'd0;
      cfg_idx_q  <= 8'd0;
      cfg_trip_q <= 8'd0;
      cfg_odd_q  <= 1'b0;
      tx_q       <= 6'd0;
      ty_q       <= 6'd0;
      ch_q       <= 8'd0;
      mode_q     <= 2'd0;
      idx_q      <= 8'd0;
      trip_q     <= 8'd0;
      is_new_q   <= 1'b1;
      pad_q      <= 4'd0;
      cut_q      <= 1'b0;
      ld_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_lim_q   <= tx_lim_d;
      ty_lim_q   <= ty_lim_d;
      cg_lim_q   <= cg_lim_d;
      cfg_mode_q <= cfg_mode_d;
      cfg_idx_q  <= cfg_idx_d;
      cfg_trip_q <= cfg_trip_d;
      cfg_odd_q  <= cfg_odd_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      ch_q       <= ch_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      trip_q     <= trip_d;
      is_new_q   <= is_new_d;
      pad_q      <= pad_d;
      cut_q      <= cut_d;
      ld_q       <= ld_d;
    end
  end

endmodule

// File: tb/tb_agu_tile_sched.sv
// Bench for agu_tile_sched: table vectors, random layers against a loop-nest model, reset/abort sequences.
module tb_agu_tile_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [5:0] cmd_tile_x;
  logic [5:0] cmd_tile_y;
  logic [7:0] cmd_ch_grp;
  logic [7:0] cmd_idx_cnt;
  logic [7:0] cmd_trip_cnt;
  logic       cmd_odd_h;
  logic       abort;
  logic       agu_done;
  logic       start;
  logic [1:0] mode;
  logic [7:0] idx_cnt;
  logic [7:0] trip_cnt;
  logic       is_new;
  logic [3:0] pad_code;
  logic       cut_y;
  logic       busy;
  logic       layer_done;

  agu_tile_sched dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_tile_x(cmd_tile_x), .cmd_tile_y(cmd_tile_y),
    .cmd_ch_grp(cmd_ch_grp), .cmd_idx_cnt(cmd_idx_cnt), .cmd_trip_cnt(cmd_trip_cnt),
    .cmd_odd_h(cmd_odd_h), .abort(abort), .agu_done(agu_done), .start(start),
    .mode(mode), .idx_cnt(idx_cnt), .trip_cnt(trip_cnt), .is_new(is_new),
    .pad_code(pad_code), .cut_y(cut_y), .busy(busy), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] m;
    logic [5:0] tx;
    logic [5:0] ty;
    logic [7:0] cg;
    logic       odd;
    logic [7:0] idx;
    logic [7:0] trip;
    int         lat;
    int         abort_tile;
    logic       abort_idle;
    int         exp_starts;
    logic [3:0] exp_pad0;
    int         exp_ld;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, int'(start), 0);
    chk({tag, "_mode"}, int'(mode), 0);
    chk({tag, "_idx"}, int'(idx_cnt), 0);
    chk({tag, "_trip"}, int'(trip_cnt), 0);
    chk({tag, "_is_new"}, int'(is_new), 1);
    chk({tag, "_pad"}, int'(pad_code), 0);
    chk({tag, "_cut"}, int'(cut_y), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_layer_done"}, int'(layer_done), 0);
  endtask

  // Runs one layer from the negedge where the DUT sits idle; returns observed
  // start count, layer_done count, first pad_code and the model's tile count.
  task automatic run_layer(input vec_t v, output int ns, output int ld,
                           output logic [3:0] pad0, output int total);
    int ex, ey, ec, j, k, done_j, last_done, abort_j, limit, exp_j;
    logic [3:0] e_pad[$];
    logic       e_cut[$];
    logic       e_new[$];
    ex = (v.m[0] || v.tx == 6'd0) ? 1 : int'(v.tx);
    ey = (v.m[0] || v.ty == 6'd0) ? 1 : int'(v.ty);
    ec = (v.cg == 8'd0) ? 1 : int'(v.cg);
    for (int c = 0; c < ec; c++)
      for (int y = 0; y < ey; y++)
        for (int x = 0; x < ex; x++) begin
          e_pad.push_back(v.m[0] ? 4'd0 : {x == ex - 1, x == 0, y == ey - 1, y == 0});
          e_cut.push_back(!v.m[0] && v.odd && (y == ey - 1));
          e_new.push_back(c == 0);
        end
    total = e_pad.size();
    ns = 0; ld = 0; pad0 = 4'd0;
    done_j = -1; last_done = -1; abort_j = -1;
    limit = total * (v.lat + 3) + 20;

    agu_done = 1'b1;
    @(negedge clk);
    agu_done = 1'b0;
    chk("idle_stray_done_busy", int'(busy), 0);
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    chk("ready_before_cmd", int'(cmd_ready), 1);

    cmd_valid = 1'b1; cmd_mode = v.m; cmd_tile_x = v.tx; cmd_tile_y = v.ty;
    cmd_ch_grp = v.cg; cmd_idx_cnt = v.idx; cmd_trip_cnt = v.trip; cmd_odd_h = v.odd;
    abort = v.abort_idle;
    @(negedge clk);
    cmd_valid = 1'b0; abort = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
    j = 1;
    while (j < limit) begin
      agu_done = 1'b0;
      abort    = 1'b0;
      if (start) begin
        exp_j = (ns == 0) ? 2 : last_done + 2;
        chk("start_cycle", j, exp_j);
        if (ns < total) begin
          chk("pad_code", int'(pad_code), int'(e_pad[ns]));
          chk("cut_y", int'(cut_y), int'(e_cut[ns]));
          chk("is_new", int'(is_new), int'(e_new[ns]));
          chk("mode", int'(mode), int'(v.m));
          chk("idx_cnt", int'(idx_cnt), int'(v.idx));
          chk("trip_cnt", int'(trip_cnt), int'(v.trip));
        end
        if (ns == 0) pad0 = pad_code;
        ns++;
        agu_done = 1'b1;  // stray pulse while in ISSUE
        if (ns - 1 == v.abort_tile) abort_j = j + 1;
        else done_j = j + v.lat;
      end
      if (j == abort_j) abort = 1'b1;
      if (abort_j >= 0 && j == abort_j + 1) chk("abort_then_idle", int'(busy), 0);
      if (j == done_j) begin agu_done = 1'b1; last_done = j; end
      if (layer_done) begin
        ld++;
        chk("layer_done_cycle", j, last_done + 1);
        chk("ready_during_layer_done", int'(cmd_ready), 0);
      end
      if (ld != 0 && j == last_done + 2) begin
        chk("ready_after_layer", int'(cmd_ready), 1);
        chk("layer_done_one_cycle", int'(layer_done), 0);
        break;
      end
      if (abort_j >= 0 && j == abort_j + 10) break;
      @(negedge clk);
      j++;
    end
    if (j >= limit) begin
      n_chk++;
      $display("FAIL layer_timeout: no completion within %0d cycles", limit);
    end
    agu_done = 1'b0;
    abort    = 1'b0;
  endtask

  vec_t vecs[6];
  vec_t rv;
  int   ns, ld, total;
  logic [3:0] pad0;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_tile_x = 6'd0; cmd_tile_y = 6'd0;
    cmd_ch_grp = 8'd0; cmd_idx_cnt = 8'd0; cmd_trip_cnt = 8'd0; cmd_odd_h = 1'b0;
    abort = 1'b0; agu_done = 1'b0;

    //          m      tx     ty     cg     odd   idx     trip  lat ab ab_idle st pad0    ld
    vecs[0] = '{2'b00, 6'd2, 6'd2, 8'd1, 1'b1, 8'h11, 8'h22, 3, -1, 1'b0, 4, 4'b0101, 1};
    vecs[1] = '{2'b00, 6'd1, 6'd1, 8'd3, 1'b0, 8'h33, 8'h44, 2, -1, 1'b0, 3, 4'b1111, 1};
    vecs[2] = '{2'b11, 6'd5, 6'd4, 8'd2, 1'b1, 8'h55, 8'h66, 1, -1, 1'b1, 2, 4'b0000, 1};
    vecs[3] = '{2'b00, 6'd0, 6'd0, 8'd0, 1'b0, 8'h77, 8'h88, 2, -1, 1'b0, 1, 4'b1111, 1};
    vecs[4] = '{2'b10, 6'd3, 6'd2, 8'd1, 1'b0, 8'h99, 8'hAA, 3,  1, 1'b0, 2, 4'b0101, 0};
    vecs[5] = '{2'b01, 6'd0, 6'd0, 8'd0, 1'b1, 8'hBB, 8'hCC, 1, -1, 1'b0, 1, 4'b0000, 1};

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(cmd_ready), 1);

    for (int i = 0; i < 6; i++) begin
      run_layer(vecs[i], ns, ld, pad0, total);
      chk($sformatf("vec%0d_starts", i), ns, vecs[i].exp_starts);
      chk($sformatf("vec%0d_pad0", i), int'(pad0), int'(vecs[i].exp_pad0));
      chk($sformatf("vec%0d_layer_done", i), ld, vecs[i].exp_ld);
    end

    for (int i = 0; i < 10; i++) begin
      rv.m = 2'($urandom_range(0, 3));
      rv.tx = 6'($urandom_range(0, 3));
      rv.ty = 6'($urandom_range(0, 3));
      rv.cg = 8'($urandom_range(0, 3));
      rv.odd = 1'($urandom_range(0, 1));
      rv.idx = 8'($urandom);
      rv.trip = 8'($urandom);
      rv.lat = $urandom_range(1, 4);
      rv.abort_tile = -1;
      rv.abort_idle = 1'($urandom_range(0, 1));
      rv.exp_starts = 0;
      rv.exp_pad0 = 4'd0;
      rv.exp_ld = 1;
      run_layer(rv, ns, ld, pad0, total);
      chk($sformatf("rand%0d_starts", i), ns, total);
      chk($sformatf("rand%0d_layer_done", i), ld, 1);
    end

    // Reset while waiting on the AGU.
    cmd_valid = 1'b1; cmd_mode = 2'b10; cmd_tile_x = 6'd3; cmd_tile_y = 6'd3;
    cmd_ch_grp = 8'd2; cmd_idx_cnt = 8'hA5; cmd_trip_cnt = 8'h3C; cmd_odd_h = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rstseq_start", int'(start), 1);
    chk("rstseq_idx", int'(idx_cnt), 8'hA5);
    chk("rstseq_mode", int'(mode), 2);
    @(negedge clk);
    chk("rstseq_busy_wait", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst_in_wait");
    rst = 1'b0;
    agu_done = 1'b1;
    @(negedge clk);
    agu_done = 1'b0;
    chk("rstseq_ready_after", int'(cmd_ready), 1);
    ld = 0;
    for (int c = 0; c < 8; c++) begin
      if (layer_done || start) ld++;
      @(negedge clk);
    end
    chk("rstseq_quiet", ld, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
